// File: rtl/int_sequencer_pkg.sv
// ============================================================================
// Module      : int_sequencer_pkg
// Description : Shared encodings, defaults and helpers for the interrupt
//               sequencer and its priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_sequencer_pkg;

    // Sequencer state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] SVC  = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    // Vector index reserved for the NMI source
    localparam logic [3:0] NMI_VEC = 4'd14;

    // Default configuration
    localparam int          NUM_IRQ_DFLT     = 14;
    localparam logic [15:0] VEC_BASE_DFLT    = 16'hFFE0;
    localparam int          SVC_TIMEOUT_DFLT = 15;

    // Arbitration result: a request is pending and which vector wins
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } arb_t;

    // Vector table entries are word sized, so each index steps by two bytes
    function automatic logic [15:0] vec_addr_of(input logic [15:0] base,
                                                input logic [3:0]  idx);
        return base + {11'd0, idx, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_sequencer_if.sv
// ============================================================================
// Module      : int_sequencer_if
// Description : Request / handshake bundle between the interrupt sources,
//               control unit, microsequencer and the interrupt sequencer.
//               master = sources + control unit side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_sequencer_if
    import int_sequencer_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DFLT
);
    logic [NUM_IRQ-1:0] irq;
    logic               nmi;
    logic               gie;
    logic               IF;
    logic               Br;
    logic               vec_fetch;
    logic               INTREQ;
    logic               INTACK;
    logic [3:0]         vec_idx;
    logic [15:0]        vec_addr;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               svc_err;

    modport master (
        output irq, nmi, gie, IF, Br, vec_fetch,
        input  INTREQ, INTACK, vec_idx, vec_addr, irq_ack, svc_err
    );

    modport slave (
        input  irq, nmi, gie, IF, Br, vec_fetch,
        output INTREQ, INTACK, vec_idx, vec_addr, irq_ack, svc_err
    );

endinterface

`default_nettype wire

// File: rtl/int_prio_enc.sv
// ============================================================================
// Module      : int_prio_enc
// Description : Combinational interrupt priority encoder. NMI beats every
//               maskable source; among maskable sources the highest set bit
//               wins, and all of them are masked by gie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_prio_enc
    import int_sequencer_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DFLT
) (
    input  logic               nmi_pend,
    input  logic               gie,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               valid,
    output logic [3:0]         index
);

    // Pick the winner; ascending scan lets the highest set bit overwrite
    always_comb begin
        valid = nmi_pend | (gie & (|irq));
        index = 4'd0;
        if (nmi_pend) begin
            index = NMI_VEC;
        end else if (gie) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (irq[i]) begin
                    index = i[3:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_sequencer.sv
// ============================================================================
// Module      : int_sequencer
// Description : Interrupt arbiter and INTREQ/INTACK handshake sequencer for
//               the CPU microsequencer. Collects NMI and maskable requests,
//               raises INTREQ, freezes the winning vector at the instruction
//               boundary and acknowledges once the vector has been fetched.
//               Optional macro IRQ_SYNC_EN: adds 2-flop synchronizers on irq
//               and nmi (two extra cycles of request latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter int          NUM_IRQ     = NUM_IRQ_DFLT,
    parameter logic [15:0] VEC_BASE    = VEC_BASE_DFLT,
    parameter int          SVC_TIMEOUT = SVC_TIMEOUT_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    int_sequencer_if.slave  bus
);

    localparam int                 CNT_W     = (SVC_TIMEOUT < 2) ? 1 : $clog2(SVC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   C_TIMEOUT = CNT_W'(SVC_TIMEOUT);
    localparam logic [NUM_IRQ-1:0] C_ONE     = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] w_irq;
    logic               w_nmi;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_irq_s1;
    logic [NUM_IRQ-1:0] r_irq_s2;
    logic               r_nmi_s1;
    logic               r_nmi_s2;

    // Two-flop synchronizers for asynchronous request sources
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_s1 <= '0;
            r_irq_s2 <= '0;
            r_nmi_s1 <= 1'b0;
            r_nmi_s2 <= 1'b0;
        end else begin
            r_irq_s1 <= bus.irq;
            r_irq_s2 <= r_irq_s1;
            r_nmi_s1 <= bus.nmi;
            r_nmi_s2 <= r_nmi_s1;
        end
    end

    assign w_irq = r_irq_s2;
    assign w_nmi = r_nmi_s2;
`else
    assign w_irq = bus.irq;
    assign w_nmi = bus.nmi;
`endif

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_nmi_q;
    logic               r_nmi_pend;
    logic               r_intreq;
    logic               r_intack;
    logic [3:0]         r_vec_idx;
    logic [15:0]        r_vec_addr;
    logic [NUM_IRQ-1:0] r_irq_ack;
    logic               r_svc_err;

    logic               w_nmi_rise;
    logic               w_nmi_clr;
    arb_t               w_arb;
    logic               w_boundary;

    assign w_nmi_rise = w_nmi & ~r_nmi_q;
    // The ACK cycle is the INTACK cycle; retire the NMI request there
    assign w_nmi_clr  = (r_state == ACK) && (r_vec_idx == NMI_VEC);
    assign w_boundary = bus.IF | bus.Br;

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .nmi_pend (r_nmi_pend),
        .gie      (bus.gie),
        .irq      (w_irq),
        .valid    (w_arb.valid),
        .index    (w_arb.idx)
    );

    // NMI edge detect; a fresh edge outranks the clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_q    <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_q <= w_nmi;
            if (w_nmi_rise) begin
                r_nmi_pend <= 1'b1;
            end else if (w_nmi_clr) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

    // Handshake FSM with registered outputs; pulses default low each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_intreq   <= 1'b0;
            r_intack   <= 1'b0;
            r_vec_idx  <= 4'd0;
            r_vec_addr <= VEC_BASE;
            r_irq_ack  <= '0;
            r_svc_err  <= 1'b0;
        end else begin
            r_intack  <= 1'b0;
            r_irq_ack <= '0;
            r_svc_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb.valid) begin
                        r_state    <= PEND;
                        r_intreq   <= 1'b1;
                        r_vec_idx  <= w_arb.idx;
                        r_vec_addr <= vec_addr_of(VEC_BASE, w_arb.idx);
                    end
                end
                PEND: begin
                    // The CAR has already branched on a boundary, so it beats withdrawal
                    if (w_boundary) begin
                        r_state  <= SVC;
                        r_intreq <= 1'b0;
                        r_cnt    <= '0;
                    end else if (!w_arb.valid) begin
                        r_state  <= IDLE;
                        r_intreq <= 1'b0;
                    end else begin
                        r_vec_idx  <= w_arb.idx;
                        r_vec_addr <= vec_addr_of(VEC_BASE, w_arb.idx);
                    end
                end
                SVC: begin
                    if (bus.vec_fetch) begin
                        r_state   <= ACK;
                        r_intack  <= 1'b1;
                        r_irq_ack <= (r_vec_idx == NMI_VEC) ? '0 : (C_ONE << r_vec_idx);
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_state   <= IDLE;
                        r_svc_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.INTREQ   = r_intreq;
    assign bus.INTACK   = r_intack;
    assign bus.vec_idx  = r_vec_idx;
    assign bus.vec_addr = r_vec_addr;
    assign bus.irq_ack  = r_irq_ack;
    assign bus.svc_err  = r_svc_err;

endmodule

`default_nettype wire

// File: tb/tb_int_sequencer.sv
// ============================================================================
// Module      : tb_int_sequencer
// Description : Self-checking bench for int_sequencer. Expected acknowledges
//               are queued as each interrupt is committed and compared when
//               INTACK appears. Honours IRQ_SYNC_EN for request latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_sequencer;
    import int_sequencer_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] addr;
        logic [13:0] ack;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_err_seen;
    exp_t sb_q[$];
    exp_t m_exp;

    int_sequencer_if #(.NUM_IRQ(14)) bus ();

    int_sequencer #(
        .NUM_IRQ     (14),
        .VEC_BASE    (16'hFFE0),
        .SVC_TIMEOUT (15)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] idx, input logic [15:0] addr, input logic [13:0] ack);
        exp_t e;
        e.idx  = idx;
        e.addr = addr;
        e.ack  = ack;
        sb_q.push_back(e);
    endtask

    // Raise a maskable request and wait until it should be visible in PEND
    task automatic go_pend(input logic [13:0] v, input string tag);
        bus.irq = v;
        bus.gie = 1'b1;
        repeat (SYNC_LAT) tick();
        check_val({tag, "_intreq_early"}, 32'(bus.INTREQ), 32'd0);
        tick();
        check_val({tag, "_intreq"}, 32'(bus.INTREQ), 32'd1);
    endtask

    // One-cycle instruction boundary, leaves the DUT in SVC cycle 0
    task automatic boundary(input bit use_br);
        if (use_br) bus.Br = 1'b1;
        else        bus.IF = 1'b1;
        tick();
        bus.IF = 1'b0;
        bus.Br = 1'b0;
    endtask

    // From SVC cycle 0, strobe vec_fetch in SVC cycle 'dly'; leaves DUT in ACK
    task automatic run_svc(input int dly, input string tag);
        repeat (dly) tick();
        bus.vec_fetch = 1'b1;
        tick();
        bus.vec_fetch = 1'b0;
        check_val({tag, "_intack"}, 32'(bus.INTACK), 32'd1);
    endtask

    // Scoreboard side: every INTACK must match the oldest committed interrupt
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.INTACK) begin
                if (sb_q.size() == 0) begin
                    check_val("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    m_exp = sb_q.pop_front();
                    check_val("ack_idx", 32'(bus.vec_idx), 32'(m_exp.idx));
                    check_val("ack_addr", 32'(bus.vec_addr), 32'(m_exp.addr));
                    check_val("ack_irq_ack", 32'(bus.irq_ack), 32'(m_exp.ack));
                end
            end else if (bus.irq_ack != 14'd0) begin
                check_val("irq_ack_stray", 32'(bus.irq_ack), 32'd0);
            end
            if (bus.svc_err) n_err_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        n_err_seen    = 0;
        rst_n         = 1'b0;
        bus.irq       = '0;
        bus.nmi       = 1'b0;
        bus.gie       = 1'b0;
        bus.IF        = 1'b0;
        bus.Br        = 1'b0;
        bus.vec_fetch = 1'b0;
        repeat (3) tick();

        // Reset state
        check_val("rst_intreq", 32'(bus.INTREQ), 32'd0);
        check_val("rst_intack", 32'(bus.INTACK), 32'd0);
        check_val("rst_vec_idx", 32'(bus.vec_idx), 32'd0);
        check_val("rst_vec_addr", 32'(bus.vec_addr), 32'hFFE0);
        check_val("rst_irq_ack", 32'(bus.irq_ack), 32'd0);
        check_val("rst_svc_err", 32'(bus.svc_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single source irq[3]
        go_pend(14'h0008, "s1");
        check_val("s1_vec_idx", 32'(bus.vec_idx), 32'd3);
        check_val("s1_vec_addr", 32'(bus.vec_addr), 32'hFFE6);
        repeat (2) tick();
        check_val("s1_intreq_hold", 32'(bus.INTREQ), 32'd1);
        boundary(1'b0);
        check_val("s1_svc_intreq", 32'(bus.INTREQ), 32'd0);
        push_exp(4'd3, 16'hFFE6, 14'h0008);
        bus.irq = '0;
        run_svc(3, "s1");
        tick();
        check_val("s1_intack_pulse", 32'(bus.INTACK), 32'd0);
        tick();
        check_val("s1_idle", 32'(bus.INTREQ), 32'd0);

        // Pre-emption irq[2] -> irq[9] while pending
        go_pend(14'h0004, "s2");
        check_val("s2_vec_idx_lo", 32'(bus.vec_idx), 32'd2);
        bus.irq = 14'h0204;
        repeat (SYNC_LAT) tick();
        tick();
        check_val("s2_vec_idx_hi", 32'(bus.vec_idx), 32'd9);
        check_val("s2_vec_addr_hi", 32'(bus.vec_addr), 32'hFFF2);
        boundary(1'b0);
        check_val("s2_frozen", 32'(bus.vec_idx), 32'd9);
        push_exp(4'd9, 16'hFFF2, 14'h0200);
        bus.irq = 14'h0004;
        run_svc(2, "s2");
        tick();
        check_val("s2_turn_idle", 32'(bus.INTREQ), 32'd0);
        tick();
        check_val("s2_repend", 32'(bus.INTREQ), 32'd1);
        check_val("s2_repend_idx", 32'(bus.vec_idx), 32'd2);
        // Withdrawal with no boundary returns to IDLE
        bus.irq = '0;
        repeat (SYNC_LAT) tick();
        check_val("s2_withdraw_hold", 32'(bus.INTREQ), 32'd1);
        tick();
        check_val("s2_withdraw_idle", 32'(bus.INTREQ), 32'd0);

        // NMI beats a masked irq[13]
        bus.gie = 1'b0;
        bus.irq = 14'h2000;
        repeat (4) tick();
        check_val("s3_gie_mask", 32'(bus.INTREQ), 32'd0);
        bus.nmi = 1'b1;
        repeat (1 + SYNC_LAT) tick();
        check_val("s3_nmi_early", 32'(bus.INTREQ), 32'd0);
        tick();
        check_val("s3_nmi_intreq", 32'(bus.INTREQ), 32'd1);
        check_val("s3_nmi_idx", 32'(bus.vec_idx), 32'd14);
        check_val("s3_nmi_addr", 32'(bus.vec_addr), 32'hFFFC);
        boundary(1'b1);
        push_exp(4'd14, 16'hFFFC, 14'h0000);
        bus.nmi = 1'b0;
        run_svc(0, "s3");
        repeat (2) tick();
        check_val("s3_nmi_cleared", 32'(bus.INTREQ), 32'd0);
        bus.irq = '0;

        // Withdrawal and boundary in the same cycle: boundary wins
        go_pend(14'h0020, "s4");
        bus.irq = '0;
        bus.Br  = 1'b1;
        tick();
        bus.Br  = 1'b0;
        check_val("s4_svc_intreq", 32'(bus.INTREQ), 32'd0);
        push_exp(4'd5, 16'hFFEA, 14'h0020);
        run_svc(1, "s4");
        repeat (2) tick();
        check_val("s4_idle", 32'(bus.INTREQ), 32'd0);

        // SVC timeout with no vec_fetch
        go_pend(14'h0002, "s5");
        boundary(1'b0);
        bus.irq = '0;
        repeat (15) tick();
        check_val("s5_err_early", 32'(bus.svc_err), 32'd0);
        tick();
        check_val("s5_err_pulse", 32'(bus.svc_err), 32'd1);
        check_val("s5_err_noack", 32'(bus.INTACK), 32'd0);
        tick();
        check_val("s5_err_clear", 32'(bus.svc_err), 32'd0);
        check_val("s5_err_idle", 32'(bus.INTREQ), 32'd0);

        // vec_fetch coincident with the timeout: fetch wins
        go_pend(14'h0002, "s5b");
        boundary(1'b0);
        bus.irq = '0;
        push_exp(4'd1, 16'hFFE2, 14'h0002);
        run_svc(15, "s5b");
        check_val("s5b_no_err", 32'(bus.svc_err), 32'd0);
        repeat (2) tick();

        // Asynchronous reset in the middle of SVC
        go_pend(14'h0010, "s6");
        boundary(1'b0);
        bus.irq = '0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s6_rst_idx", 32'(bus.vec_idx), 32'd0);
        check_val("s6_rst_addr", 32'(bus.vec_addr), 32'hFFE0);
        check_val("s6_rst_intreq", 32'(bus.INTREQ), 32'd0);
        check_val("s6_rst_intack", 32'(bus.INTACK), 32'd0);
        bus.vec_fetch = 1'b1;
        repeat (2) tick();
        bus.vec_fetch = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        check_val("s6_post_rst", 32'(bus.INTREQ), 32'd0);
        check_val("s6_post_intack", 32'(bus.INTACK), 32'd0);

        // Final scoreboard state
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        check_val("svc_err_count", 32'(n_err_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
